// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the elastic pipeline register.
package pipe_reg_pkg;

   // Width of a counter able to hold 0..depth.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Per-stage handshake view, grouped so both bits sit together in waveforms.
   typedef struct packed {
      logic vld;
      logic rdy;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: a valid bit plus a data word.
// Data is only overwritten by valid data; flush clears the valid bit and keeps the data.
module pipe_stage
   import pipe_reg_pkg::*;
#(
   parameter int unsigned            WIDTH       = 32,
   parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             flush,
   input  logic             src_vld,
   input  logic [WIDTH-1:0] src_data,
   output logic             vld_q,
   output logic [WIDTH-1:0] data_q
);

   // Stage state: reset beats flush, flush beats load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q  <= 1'b0;
         data_q <= RESET_VALUE;
      end else if (flush) begin
         vld_q <= 1'b0;
      end else if (load) begin
         vld_q <= src_vld;
         if (src_vld) begin
            data_q <= src_data;
         end
      end
   end

endmodule

// File: rtl/pipe_reg_param.sv
// Elastic pipeline register: DEPTH handshaked stages of WIDTH-bit data.
// Optional build macro PIPE_REG_OCC_EN adds a registered occupancy count output.
// The out_ready -> in_ready path is combinational by design.
module pipe_reg_param
   import pipe_reg_pkg::*;
#(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_REG_OCC_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] vld_q;
   logic [WIDTH-1:0] data_q [DEPTH];
   stage_ctrl_t      ctrl   [DEPTH];
   logic             go;

   assign go = en & ~flush;

   // Ready chain: a stage can take data if it, or any stage after it, has a free slot,
   // or the consumer is taking the last one. Written as a running AND to avoid a
   // self-referencing vector.
   always_comb begin
      logic all_vld;
      all_vld = 1'b1;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         all_vld     = all_vld & vld_q[k];
         ctrl[k].vld = vld_q[k];
         ctrl[k].rdy = out_ready | ~all_vld;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             src_vld;
      logic [WIDTH-1:0] src_data;

      if (k == 0) begin : g_head
         assign src_vld  = in_valid;
         assign src_data = in_data;
      end else begin : g_body
         assign src_vld  = ctrl[k-1].vld;
         assign src_data = data_q[k-1];
      end

      pipe_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .load     (go & ctrl[k].rdy),
         .flush    (flush),
         .src_vld  (src_vld),
         .src_data (src_data),
         .vld_q    (vld_q[k]),
         .data_q   (data_q[k])
      );
   end

   assign in_ready  = go & ctrl[0].rdy;
   assign out_valid = go & ctrl[DEPTH-1].vld;
   assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
   localparam int unsigned OccW = occ_width(DEPTH);

   logic [OccW-1:0] occ_q;
   logic            accept;
   logic            pop;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Occupancy tracks handshakes; accept and pop are already gated by en and flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_q + OccW'(accept) - OccW'(pop);
      end
   end

   assign occupancy = occ_q;

   occ_matches_vld : assert property (@(posedge clk) disable iff (!rst)
      occ_q == OccW'($countones(vld_q)));
`endif

endmodule

// File: tb/tb_pipe_reg_param.sv
// Bench for pipe_reg_param: directed scenarios plus random traffic, checked each cycle
// against an item-list model (each in-flight item carries its data and stage position).
module tb_pipe_reg_param;

   localparam int unsigned   WIDTH   = 16;
   localparam int            DEPTH   = 3;
   localparam logic [15:0]   RST_VAL = 16'hA5A5;

   logic        clk;
   logic        rst;
   logic        en;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
`ifdef PIPE_REG_OCC_EN
   logic [1:0]  occupancy;
`endif

   pipe_reg_param #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .RESET_VALUE (RST_VAL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef PIPE_REG_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: in-flight items, oldest first, with their stage positions.
   int          m_pos [$];
   logic [15:0] m_dat [$];
   logic [15:0] m_last;   // last value written into the final stage

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
   task automatic step(input logic r, input logic e, input logic f, input logic iv,
                       input logic [15:0] d, input logic ordy);
      bit mv [];
      int n;
      bit slot0_ok;
      bit exp_ov;
      bit exp_ir;
      rst       = r;
      en        = e;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      n  = m_pos.size();
      mv = new[n];
      for (int i = 0; i < n; i++) begin
         if (i == 0) mv[i] = (m_pos[0] == DEPTH - 1) ? ordy : 1'b1;
         else        mv[i] = (m_pos[i] + 1 < m_pos[i-1]) || mv[i-1];
      end
      slot0_ok = (n == 0) || (m_pos[n-1] != 0) || mv[n-1];
      exp_ov   = e && !f && (n > 0) && (m_pos[0] == DEPTH - 1);
      exp_ir   = e && !f && slot0_ok;
      check_val("in_ready", 32'(in_ready), 32'(exp_ir));
      check_val("out_valid", 32'(out_valid), 32'(exp_ov));
      check_val("out_data", 32'(out_data), 32'(m_last));
`ifdef PIPE_REG_OCC_EN
      check_val("occupancy", 32'(occupancy), 32'(n));
`endif
      @(posedge clk);
      if (!r || f) begin
         m_pos.delete();
         m_dat.delete();
         if (!r) m_last = RST_VAL;
      end else if (e) begin
         for (int i = 0; i < n; i++) begin
            if (mv[i]) begin
               m_pos[i] = m_pos[i] + 1;
               if (m_pos[i] == DEPTH - 1) m_last = m_dat[i];
            end
         end
         if (n > 0 && m_pos[0] == DEPTH) begin
            void'(m_pos.pop_front());
            void'(m_dat.pop_front());
         end
         if (iv && exp_ir) begin
            m_pos.push_back(0);
            m_dat.push_back(d);
            if (DEPTH == 1) m_last = d;
         end
      end
      #1;
   endtask

   initial begin
      m_last    = RST_VAL;
      rst       = 1'b0;
      en        = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0077;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with valid input present
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0077, 1'b1);

      // Streaming 1..8 then drain
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 16'(i), 1'b1);
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

      // Back-pressure: 0xD held until the consumer pops 0xA
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000A, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000C, 1'b0);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000D, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000D, 1'b1);
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

      // Bubble collapse
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0006, 1'b0);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

      // Flush with valid input present: 0xF must be dropped
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 16'(i), 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h000F, 1'b0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

      // Enable dropped for 4 cycles mid-stream
      for (int i = 0; i < 14; i++) begin
         step(1'b1, !(i >= 4 && i < 8), 1'b0, 1'b1, 16'h0020 + 16'(i), 1'b1);
      end
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(99) >= 1, $urandom_range(99) < 90, $urandom_range(99) < 3,
              $urandom_range(99) < 70, 16'($urandom), $urandom_range(99) < 60);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
